cam_pixel_packer: RTL and testbench

Packs the raw 8-bit pixel stream from the camera capture stage into 64-bit words and presents them on a valid/ready stream for the downstream DMA/frame-writer. Sits directly after the capture stage in the `pclk` domain, framed by the capture stage's vsync-derived frame-start pulse. Absorbs downstream backpressure in a small FIFO, because the camera cannot be stalled. Overflow is reported rather than stalling.

---
 rtl/cam_pixel_packer.sv | 149 ++++++++++++++
 tb/tb_cam_pixel_packer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_packer.sv
// Packs an 8-bit camera pixel stream into 64-bit words behind a show-ahead word FIFO.
// Optional build macro: CAM_PACKER_DROP_CNT_EN enables the saturating drop_cnt counter.
module cam_pixel_packer #(
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic [7:0]  pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        overflow,
    output logic        short_frame,
    output logic [15:0] frame_count,
    output logic [31:0] drop_cnt
);
    localparam int unsigned PCW = $clog2(FRAME_PIXELS + 1);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam logic [PCW-1:0] FP_L   = PCW'(FRAME_PIXELS);
    localparam logic [AW:0]    FULL_L = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_e;

    state_e         state_q;
    logic [63:0]    acc_q;
    logic [2:0]     byte_idx_q;
    logic [PCW-1:0] pix_cnt_q;
    logic           push_vld_q;
    logic [63:0]    push_data_q;
    logic           push_last_q;
    logic           short_q;
    logic           overflow_q;
    logic [15:0]    frame_cnt_q;

    logic           flush;
    logic           take;
    logic [2:0]     lane_d;
    logic [PCW-1:0] cnt_d;
    logic [63:0]    acc_d;
    logic           last_d;

    // A flush frees the accumulator first, so a coincident byte lands in lane 0.
    always_comb begin
        flush  = (state_q == ACTIVE) && frame_start && (pix_cnt_q != '0);
        take   = pixel_valid && ((state_q == ACTIVE) || ((state_q == WAIT_FRAME) && frame_start));
        lane_d = flush ? 3'd0 : byte_idx_q;
        cnt_d  = (flush ? '0 : pix_cnt_q) + PCW'(1);
        acc_d  = (flush ? '0 : acc_q) | ({56'd0, pixel} << {lane_d, 3'b000});
        last_d = (cnt_d == FP_L);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            byte_idx_q  <= '0;
            pix_cnt_q   <= '0;
            push_vld_q  <= 1'b0;
            push_data_q <= '0;
            push_last_q <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            push_vld_q <= 1'b0;
            case (state_q)
                IDLE:       if (start) state_q <= WAIT_FRAME;
                WAIT_FRAME: if (frame_start) state_q <= ACTIVE;
                default:    ;
            endcase
            if (flush) begin
                push_vld_q  <= 1'b1;
                push_data_q <= acc_q;
                push_last_q <= 1'b1;
                short_q     <= 1'b1;
            end
            if (take) begin
                if (lane_d == 3'd7) begin
                    push_vld_q  <= 1'b1;
                    push_data_q <= acc_d;
                    push_last_q <= last_d;
                    acc_q       <= '0;
                    byte_idx_q  <= '0;
                    pix_cnt_q   <= last_d ? '0 : cnt_d;
                    if (last_d) state_q <= WAIT_FRAME;
                end else begin
                    acc_q      <= acc_d;
                    byte_idx_q <= lane_d + 3'd1;
                    pix_cnt_q  <= cnt_d;
                end
            end else if (flush) begin
                acc_q      <= '0;
                byte_idx_q <= '0;
                pix_cnt_q  <= '0;
            end
        end
    end

    logic [64:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        empty;
    logic        full;
    logic        drop;

    // Full is judged on registered occupancy, so a same-cycle pop does not make room.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q - rd_ptr_q) == FULL_L);
    assign drop  = push_vld_q && full;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (push_vld_q && !full) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {push_last_q, push_data_q};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (!empty && out_ready) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop) overflow_q <= 1'b1;
            if (push_vld_q && push_last_q) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign out_valid             = !empty;
    assign {out_last, out_data}  = empty ? 65'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow              = overflow_q;
    assign short_frame           = short_q;
    assign frame_count           = frame_cnt_q;

`ifdef CAM_PACKER_DROP_CNT_EN
    logic [31:0] drop_cnt_q;
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)                       drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Self-checking bench for cam_pixel_packer: queue-based reference model plus directed literal checks.
module tb_cam_pixel_packer;
    localparam int unsigned FP    = 16;
    localparam int unsigned DEPTH = 4;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        frame_start = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [7:0]  pixel = 8'd0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_last;
    logic        overflow;
    logic        short_frame;
    logic [15:0] frame_count;
    logic [31:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    cam_pixel_packer #(.FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH)) dut (
        .pclk(pclk), .rst_n(rst_n), .start(start), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .pixel(pixel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .overflow(overflow), .short_frame(short_frame),
        .frame_count(frame_count), .drop_cnt(drop_cnt)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        logic        l;
    } word_t;

    // Reference model: bytes collected per word, FIFO as a queue, push lands one cycle later.
    word_t        m_fifo[$];
    logic [7:0]   m_bytes[$];
    int           m_mode = 0;   // 0 unarmed, 1 waiting for frame, 2 in frame
    int           m_pix = 0;
    bit           m_pend = 0;
    word_t        m_pw;
    bit           m_full = 0;
    bit           m_ovf = 0;
    bit           m_short = 0;
    int unsigned  m_frames = 0;
    int unsigned  m_drops = 0;

    function automatic void emit(input bit last);
        logic [63:0] w;
        w = '0;
        foreach (m_bytes[i]) w[i*8 +: 8] = m_bytes[i];
        m_pw.d = w;
        m_pw.l = last;
        m_pend = 1;
        m_bytes.delete();
    endfunction

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_bytes.delete();
            m_mode = 0; m_pix = 0; m_pend = 0;
            m_ovf = 0; m_short = 0; m_frames = 0; m_drops = 0;
        end else begin
            m_full = (m_fifo.size() == DEPTH);
            if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
            if (m_pend) begin
                if (m_full) begin
                    m_ovf = 1;
                    if (m_drops != 32'hFFFF_FFFF) m_drops++;
                end else begin
                    m_fifo.push_back(m_pw);
                end
                if (m_pw.l) m_frames++;
            end
            m_pend = 0;
            if (m_mode == 2 && frame_start && m_pix > 0) begin
                emit(1);
                m_short = 1;
                m_pix = 0;
            end
            if (m_mode == 1 && frame_start) m_mode = 2;
            if (m_mode == 2 && pixel_valid) begin
                m_bytes.push_back(pixel);
                m_pix++;
                if (m_bytes.size() == 8) begin
                    emit(m_pix == FP);
                    if (m_pix == FP) begin
                        m_pix = 0;
                        m_mode = 1;
                    end
                end
            end
            if (m_mode == 0 && start) m_mode = 1;
        end
    end

    function automatic logic [31:0] exp_drops(input int unsigned n);
`ifdef CAM_PACKER_DROP_CNT_EN
        return n;
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    always @(negedge pclk) begin
        check64("m_out_valid", 64'(out_valid), 64'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            check64("m_out_data", out_data, m_fifo[0].d);
            check64("m_out_last", 64'(out_last), 64'(m_fifo[0].l));
        end
        check64("m_overflow", 64'(overflow), 64'(m_ovf));
        check64("m_short_frame", 64'(short_frame), 64'(m_short));
        check64("m_frame_count", 64'(frame_count), 64'(16'(m_frames)));
        check64("m_drop_cnt", 64'(drop_cnt), 64'(exp_drops(m_drops)));
    end

    word_t got[$];
    always @(negedge pclk) begin
        if (out_valid && out_ready) got.push_back('{d: out_data, l: out_last});
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        pixel = b;
        pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic check_word(input string name, input int idx, input logic [63:0] d, input logic l);
        if (got.size() > idx) begin
            check64({name, "_data"}, got[idx].d, d);
            check64({name, "_last"}, 64'(got[idx].l), 64'(l));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s missing word %0d (got %0d words)", name, idx, got.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        rst_n = 1'b1;
        check64("rst_out_valid", 64'(out_valid), 64'd0);
        check64("rst_out_data", out_data, 64'd0);
        check64("rst_frame_count", 64'(frame_count), 64'd0);
        check64("rst_overflow", 64'(overflow), 64'd0);
        check64("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Full frame of 16 bytes, then a stray byte after the frame completes
        out_ready = 1'b1;
        pulse_start();
        pulse_fs();
        for (int i = 0; i < 16; i++) send(8'(i));
        idle(4);
        check64("full_nwords", 64'(got.size()), 64'd2);
        check_word("full_w0", 0, 64'h0706050403020100, 1'b0);
        check_word("full_w1", 1, 64'h0F0E0D0C0B0A0908, 1'b1);
        check64("full_frame_count", 64'(frame_count), 64'd1);
        got.delete();
        send(8'h55);
        idle(12);
        check64("stray_nwords", 64'(got.size()), 64'd0);

        // Short frame: 11 bytes then frame_start
        pulse_fs();
        for (int i = 0; i < 11; i++) send(8'(8'h10 + i));
        idle(2);
        pulse_fs();
        idle(4);
        check_word("short_w0", 0, 64'h1716151413121110, 1'b0);
        check_word("short_w1", 1, 64'h00000000001A1918, 1'b1);
        check64("short_flag", 64'(short_frame), 64'd1);
        check64("short_frame_count", 64'(frame_count), 64'd2);
        got.delete();

        // frame_start coincident with a byte while 3 bytes pending
        send(8'h21); send(8'h22); send(8'h23);
        frame_start = 1'b1;
        pixel = 8'hAA;
        pixel_valid = 1'b1;
        tick();
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        for (int i = 1; i < 8; i++) send(8'(8'hB0 + i));
        idle(4);
        check_word("simul_flush", 0, 64'h0000000000232221, 1'b1);
        check_word("simul_next", 1, 64'hB7B6B5B4B3B2B1AA, 1'b0);
        for (int i = 0; i < 8; i++) send(8'(8'hC0 + i));
        idle(4);
        check_word("simul_end", 2, 64'hC7C6C5C4C3C2C1C0, 1'b1);
        check64("simul_frame_count", 64'(frame_count), 64'd4);
        got.delete();

        // Backpressure: 48 bytes with consumer stalled
        out_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            pulse_fs();
            for (int i = 0; i < 16; i++) send(8'(f * 16 + i));
            idle(4);
        end
        check64("bp_out_valid", 64'(out_valid), 64'd1);
        check64("bp_overflow", 64'(overflow), 64'd1);
`ifdef CAM_PACKER_DROP_CNT_EN
        check64("bp_drop_cnt", 64'(drop_cnt), 64'd2);
`else
        check64("bp_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        check64("bp_frame_count", 64'(frame_count), 64'd7);
        out_ready = 1'b1;
        idle(8);
        out_ready = 1'b0;
        check64("bp_nwords", 64'(got.size()), 64'd4);
        check_word("bp_w0", 0, 64'h0706050403020100, 1'b0);
        check_word("bp_w1", 1, 64'h0F0E0D0C0B0A0908, 1'b1);
        check_word("bp_w2", 2, 64'h1716151413121110, 1'b0);
        check_word("bp_w3", 3, 64'h1F1E1D1C1B1A1918, 1'b1);
        check64("bp_drained", 64'(out_valid), 64'd0);
        got.delete();

        // Asynchronous reset while active with a non-empty FIFO
        pulse_fs();
        for (int i = 0; i < 8; i++) send(8'(8'h60 + i));
        idle(3);
        check64("ar_pre_valid", 64'(out_valid), 64'd1);
        send(8'h68); send(8'h69); send(8'h6A);
        #2;
        rst_n = 1'b0;
        #1;
        check64("ar_out_valid", 64'(out_valid), 64'd0);
        check64("ar_frame_count", 64'(frame_count), 64'd0);
        check64("ar_overflow", 64'(overflow), 64'd0);
        check64("ar_short", 64'(short_frame), 64'd0);
        check64("ar_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        pulse_fs();
        for (int i = 0; i < 8; i++) send(8'(8'h50 + i));
        idle(4);
        check64("ar_ignored", 64'(got.size()), 64'd0);
        pulse_start();
        pulse_fs();
        for (int i = 0; i < 8; i++) send(8'(8'h70 + i));
        idle(4);
        check64("ar_rearm_nwords", 64'(got.size()), 64'd1);
        check_word("ar_rearm", 0, 64'h7776757473727170, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
